// File: rtl/mem_access_stage.sv
// MEM stage: issues word loads/stores over a req/ready handshake and registers results for MEM2WB.
// Faults (misalignment, memory timeout) turn into single-cycle error pulses so the pipeline never deadlocks.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemtoReg_in,
  input  logic [31:0] pc_in,
  input  logic        DataC_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [4:0]  write_reg_out,
  output logic [31:0] AluResOut,
  output logic [31:0] MemDataOut,
  output logic        MemtoRegOut,
  output logic [31:0] pc_out,
  output logic        DatacOut,
  output logic        align_err,
  output logic        timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [4:0]  lat_write_reg;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;
  logic        lat_we;
  logic        lat_load;
  logic        lat_memtoreg;
  logic        lat_datac;

  logic mem_op;
  logic start_access;
  logic publish_in;
  logic misaligned;
  logic done;
  logic abort;

  assign mem_op = MemRead_in | MemWrite_in;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    start_access = 1'b0;
    publish_in   = 1'b0;
    misaligned   = 1'b0;
    done         = 1'b0;
    abort        = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (mem_op && (alu_result_in[1:0] == 2'b00)) begin
            start_access = 1'b1;
            cnt_d        = '0;
            state_d      = BUSY;
          end else begin
            // Misaligned memory ops retire like ALU ops, flagged instead of accessed
            publish_in = 1'b1;
            misaligned = mem_op;
          end
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write_reg <= '0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_pc        <= '0;
      lat_we        <= 1'b0;
      lat_load      <= 1'b0;
      lat_memtoreg  <= 1'b0;
      lat_datac     <= 1'b0;
    end else if (start_access) begin
      lat_write_reg <= write_reg_in;
      lat_addr      <= alu_result_in;
      lat_wdata     <= store_data_in;
      lat_pc        <= pc_in;
      lat_we        <= MemWrite_in;
      lat_load      <= MemRead_in & ~MemWrite_in;
      lat_memtoreg  <= MemtoReg_in;
      lat_datac     <= DataC_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      align_err     <= 1'b0;
      timeout_err   <= 1'b0;
      write_reg_out <= '0;
      AluResOut     <= '0;
      MemDataOut    <= '0;
      MemtoRegOut   <= 1'b0;
      pc_out        <= '0;
      DatacOut      <= 1'b0;
    end else begin
      valid_out   <= publish_in | done | abort;
      align_err   <= misaligned;
      timeout_err <= abort;
      if (publish_in) begin
        write_reg_out <= write_reg_in;
        AluResOut     <= alu_result_in;
        MemDataOut    <= '0;
        MemtoRegOut   <= MemtoReg_in;
        pc_out        <= pc_in;
        DatacOut      <= DataC_in;
      end else if (done || abort) begin
        write_reg_out <= lat_write_reg;
        AluResOut     <= lat_addr;
        MemDataOut    <= (done && lat_load) ? dmem_rdata : '0;
        MemtoRegOut   <= lat_memtoreg;
        pc_out        <= lat_pc;
        DatacOut      <= lat_datac;
      end
    end
  end

  assign stall_out  = (state == BUSY);
  assign dmem_req   = (state == BUSY);
  assign dmem_we    = (state == BUSY) & lat_we;
  assign dmem_addr  = {lat_addr[31:2], 2'b00};
  assign dmem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [4:0]  write_reg_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        MemtoReg_in;
  logic [31:0] pc_in;
  logic        DataC_in;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [4:0]  write_reg_out;
  logic [31:0] AluResOut;
  logic [31:0] MemDataOut;
  logic        MemtoRegOut;
  logic [31:0] pc_out;
  logic        DatacOut;
  logic        align_err;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .write_reg_in(write_reg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in),
    .pc_in(pc_in), .DataC_in(DataC_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
    .write_reg_out(write_reg_out), .AluResOut(AluResOut), .MemDataOut(MemDataOut),
    .MemtoRegOut(MemtoRegOut), .pc_out(pc_out), .DatacOut(DatacOut),
    .align_err(align_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: one outstanding instruction, retired on ready or after TO unanswered cycles.
  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic        rd;
    logic        wrt;
    logic        m2r;
    logic        dc;
  } instr_t;

  instr_t      m_hold;
  logic        m_busy;
  int          m_wait;
  logic        e_valid, e_aerr, e_terr, e_m2r, e_dc;
  logic [4:0]  e_wr;
  logic [31:0] e_alu, e_md, e_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold <= '0; m_busy <= 1'b0; m_wait <= 0;
      e_valid <= 1'b0; e_aerr <= 1'b0; e_terr <= 1'b0; e_m2r <= 1'b0; e_dc <= 1'b0;
      e_wr <= '0; e_alu <= '0; e_md <= '0; e_pc <= '0;
    end else begin
      e_valid <= 1'b0; e_aerr <= 1'b0; e_terr <= 1'b0;
      if (m_busy) begin
        if (dmem_ready || (m_wait + 1 == TO)) begin
          m_busy <= 1'b0;
          e_valid <= 1'b1; e_wr <= m_hold.wr; e_alu <= m_hold.alu; e_pc <= m_hold.pc;
          e_m2r <= m_hold.m2r; e_dc <= m_hold.dc;
          e_md <= (dmem_ready && m_hold.rd && !m_hold.wrt) ? dmem_rdata : 32'h0;
          e_terr <= !dmem_ready;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (valid_in) begin
        if ((MemRead_in || MemWrite_in) && alu_result_in[1:0] == 2'b00) begin
          m_hold <= '{wr: write_reg_in, alu: alu_result_in, sd: store_data_in, pc: pc_in,
                      rd: MemRead_in, wrt: MemWrite_in, m2r: MemtoReg_in, dc: DataC_in};
          m_busy <= 1'b1;
          m_wait <= 0;
        end else begin
          e_valid <= 1'b1; e_wr <= write_reg_in; e_alu <= alu_result_in; e_pc <= pc_in;
          e_m2r <= MemtoReg_in; e_dc <= DataC_in; e_md <= 32'h0;
          e_aerr <= MemRead_in || MemWrite_in;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m.valid_out", 32'(valid_out), 32'(e_valid));
    check("m.align_err", 32'(align_err), 32'(e_aerr));
    check("m.timeout_err", 32'(timeout_err), 32'(e_terr));
    check("m.write_reg_out", 32'(write_reg_out), 32'(e_wr));
    check("m.AluResOut", AluResOut, e_alu);
    check("m.MemDataOut", MemDataOut, e_md);
    check("m.MemtoRegOut", 32'(MemtoRegOut), 32'(e_m2r));
    check("m.pc_out", pc_out, e_pc);
    check("m.DatacOut", 32'(DatacOut), 32'(e_dc));
    check("m.stall_out", 32'(stall_out), 32'(m_busy));
    check("m.dmem_req", 32'(dmem_req), 32'(m_busy));
    if (m_busy) begin
      check("m.dmem_addr", dmem_addr, {m_hold.alu[31:2], 2'b00});
      check("m.dmem_we", 32'(dmem_we), 32'(m_hold.wrt));
      check("m.dmem_wdata", dmem_wdata, m_hold.sd);
    end
  endtask

  // Every cycle: compare against the model at negedge, then step past the next posedge.
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [4:0] rg,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc,
                       input logic m2r, input logic dc);
    valid_in = v; MemRead_in = rd; MemWrite_in = wr; write_reg_in = rg;
    alu_result_in = alu; store_data_in = sd; pc_in = pc; MemtoReg_in = m2r; DataC_in = dc;
  endtask

  initial begin
    rst_n = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("rst.valid_out", 32'(valid_out), 0);
    check("rst.stall_out", 32'(stall_out), 0);
    check("rst.dmem_req", 32'(dmem_req), 0);
    check("rst.AluResOut", AluResOut, 0);
    rst_n = 1'b1;
    tick();

    // ALU passthrough, three back-to-back
    drive(1, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h40, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("alu.valid_out", 32'(valid_out), 1);
      check("alu.AluResOut", AluResOut, 32'h1234);
      check("alu.write_reg_out", 32'(write_reg_out), 5);
      check("alu.pc_out", pc_out, 32'h40);
      check("alu.stall_out", 32'(stall_out), 0);
    end
    drive(0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h40, 0, 1);
    tick();
    check("bubble.valid_out", 32'(valid_out), 0);
    check("bubble.AluResOut", AluResOut, 32'h1234);

    // Load, ready on the third request cycle
    drive(1, 1, 0, 5'd7, 32'h100, 32'h0, 32'h44, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ld.stall1", 32'(stall_out), 1);
    check("ld.dmem_addr", dmem_addr, 32'h100);
    check("ld.dmem_we", 32'(dmem_we), 0);
    check("ld.valid_out", 32'(valid_out), 0);
    tick();
    check("ld.stall2", 32'(stall_out), 1);
    tick();
    check("ld.stall3", 32'(stall_out), 1);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    check("ld.valid_out", 32'(valid_out), 1);
    check("ld.MemDataOut", MemDataOut, 32'hDEADBEEF);
    check("ld.AluResOut", AluResOut, 32'h100);
    check("ld.MemtoRegOut", 32'(MemtoRegOut), 1);
    check("ld.stall_out", 32'(stall_out), 0);

    // Store answered on the first request cycle, ALU op held behind it
    drive(1, 0, 1, 5'd0, 32'h204, 32'hCAFEF00D, 32'h48, 0, 1);
    tick();
    check("st.dmem_we", 32'(dmem_we), 1);
    check("st.dmem_wdata", dmem_wdata, 32'hCAFEF00D);
    check("st.dmem_addr", dmem_addr, 32'h204);
    drive(1, 0, 0, 5'd9, 32'h55, 32'h0, 32'h4C, 0, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'h99999999;
    tick();
    dmem_ready = 1'b0;
    check("st.valid_out", 32'(valid_out), 1);
    check("st.AluResOut", AluResOut, 32'h204);
    check("st.MemDataOut", MemDataOut, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("held.valid_out", 32'(valid_out), 1);
    check("held.AluResOut", AluResOut, 32'h55);
    check("held.write_reg_out", 32'(write_reg_out), 9);

    // Misaligned load
    drive(1, 1, 0, 5'd3, 32'h102, 32'h0, 32'h50, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mis.dmem_req", 32'(dmem_req), 0);
    check("mis.valid_out", 32'(valid_out), 1);
    check("mis.align_err", 32'(align_err), 1);
    check("mis.MemDataOut", MemDataOut, 32'h0);
    check("mis.AluResOut", AluResOut, 32'h102);
    tick();
    check("mis.pulse", 32'(align_err), 0);

    // Timeout: TO unanswered request cycles
    drive(1, 1, 0, 5'd4, 32'h300, 32'h0, 32'h54, 1, 0);
    dmem_rdata = 32'h11111111;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      check("to.dmem_req", 32'(dmem_req), 1);
      tick();
    end
    check("to.timeout_err", 32'(timeout_err), 1);
    check("to.valid_out", 32'(valid_out), 1);
    check("to.MemDataOut", MemDataOut, 32'h0);
    check("to.AluResOut", AluResOut, 32'h300);
    check("to.stall_out", 32'(stall_out), 0);
    tick();
    check("to.pulse", 32'(timeout_err), 0);

    // Reset in the middle of an outstanding load; late ready ignored
    drive(1, 1, 0, 5'd6, 32'h100, 32'h0, 32'h58, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rb.stall_before", 32'(stall_out), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rb.dmem_req", 32'(dmem_req), 0);
    check("rb.stall_out", 32'(stall_out), 0);
    check("rb.valid_out", 32'(valid_out), 0);
    tick();
    rst_n = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'h00000BAD;
    tick();
    dmem_ready = 1'b0;
    check("rb.late_valid", 32'(valid_out), 0);
    check("rb.late_data", MemDataOut, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
